// File: rtl/nonrestoring_divider.sv
// Sequential non-restoring divider: 2N-bit unsigned dividend by N-bit divisor,
// one quotient bit per clock, with divide-by-zero and quotient-overflow early exits.
module nonrestoring_divider #(
  parameter int N = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2*N-1:0]   dividend,
  input  logic [N-1:0]     divisor,
  output logic [N-1:0]     quotient,
  output logic [N-1:0]     remainder,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic             ovf
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t                r_state;
  logic signed [N:0]     r_rem;
  logic        [N-1:0]   r_q;
  logic        [N-1:0]   r_div;
  logic        [CW-1:0]  r_cnt;
  logic        [N-1:0]   r_quotient;
  logic        [N-1:0]   r_remainder;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_dbz;
  logic                  r_ovf;

  // One non-restoring iteration: shift in the next dividend bit, then
  // subtract or add the divisor depending on the sign before the shift.
  function automatic logic signed [N:0] nr_step(
    input logic signed [N:0] rem,
    input logic              next_bit,
    input logic [N-1:0]      d
  );
    logic signed [N:0] sh;
    logic signed [N:0] dx;
    sh = {rem[N-1:0], next_bit};
    dx = {1'b0, d};
    return rem[N] ? (sh + dx) : (sh - dx);
  endfunction

  // A negative final partial remainder is corrected by one divisor add-back.
  function automatic logic signed [N:0] nr_fix(
    input logic signed [N:0] rem,
    input logic [N-1:0]      d
  );
    logic signed [N:0] dx;
    dx = {1'b0, d};
    return rem[N] ? (rem + dx) : rem;
  endfunction

  logic signed [N:0] w_rem_step;
  logic signed [N:0] w_rem_fix;
  logic [N-1:0]      w_hi;
  logic              w_last;

  assign w_rem_step = nr_step(r_rem, r_q[N-1], r_div);
  assign w_rem_fix  = nr_fix(r_rem, r_div);
  assign w_hi       = dividend[2*N-1:N];
  assign w_last     = (r_cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_q         <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_div <= divisor;
            if (divisor == '0) begin
              r_dbz       <= 1'b1;
              r_ovf       <= 1'b0;
              r_quotient  <= '0;
              r_remainder <= '0;
              r_done      <= 1'b1;
              r_state     <= DONE;
            end else if (w_hi >= divisor) begin
              // Quotient would not fit in N bits; saturate instead of iterating.
              r_ovf       <= 1'b1;
              r_dbz       <= 1'b0;
              r_quotient  <= '1;
              r_remainder <= '0;
              r_done      <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_rem   <= {1'b0, w_hi};
              r_q     <= dividend[N-1:0];
              r_cnt   <= '0;
              r_dbz   <= 1'b0;
              r_ovf   <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_rem <= w_rem_step;
          r_q   <= {r_q[N-2:0], ~w_rem_step[N]};
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_rem       <= w_rem_fix;
          r_quotient  <= r_q;
          r_remainder <= w_rem_fix[N-1:0];
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbz       = r_dbz;
  assign ovf       = r_ovf;

endmodule

// File: doc/nonrestoring_divider.md
NONRESTORING_DIVIDER -- requirements
Module: nonrestoring_divider

Interface
REQ-001 SHALL have parameter N, default 25, meaning divisor/quotient/remainder width; dividend is 2N bits, matching the multiplier product width.
REQ-002 SHALL have port clk  input  1  rising-edge clock; sole clock.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port dividend  input  2N  unsigned dividend; sampled with start.
REQ-006 SHALL have port divisor  input  N  unsigned divisor; sampled with start.
REQ-007 SHALL have port quotient  output  N  unsigned quotient; registered.
REQ-008 SHALL have port remainder  output  N  unsigned remainder; registered.
REQ-009 SHALL have port busy  output  1  high in RUN and FIX.
REQ-010 SHALL have port done  output  1  one-cycle pulse; results valid.
REQ-011 SHALL have port dbz  output  1  divide-by-zero flag, valid with done.
REQ-012 SHALL have port ovf  output  1  quotient-overflow flag, valid with done.

Function
REQ-013 SHALL implement states IDLE, RUN, FIX, DONE; all outputs registered.
REQ-014 IDLE, start=1: SHALL latch dividend and divisor into internal registers; later input changes have no effect.
REQ-015 IDLE, start=1, divisor==0: SHALL set dbz=1, ovf=0, quotient=0, remainder=0 and go to DONE.
REQ-016 IDLE, start=1, divisor!=0, dividend[2N-1:N] >= divisor: SHALL set ovf=1, dbz=0, quotient=all ones, remainder=0 and go to DONE.
REQ-017 IDLE, start=1, otherwise: SHALL load partial remainder R (N+1 bits, signed) = {0, dividend[2N-1:N]}, Q = dividend[N-1:0], count=0, clear dbz/ovf, go to RUN.
REQ-018 RUN, each cycle: SHALL shift {R,Q} left one bit; if the pre-shift R sign is 0 then R = shifted R - {0,divisor}, else R = shifted R + {0,divisor}; Q[0] = inverted sign of new R; count increments.
REQ-019 RUN SHALL execute exactly N iterations, then go to FIX; count width SHALL be ceil(log2(N+1)) bits.
REQ-020 FIX: if R sign is 1, SHALL add {0,divisor} to R; SHALL load quotient=Q, remainder=R[N-1:0]; go to DONE.
REQ-021 DONE: SHALL assert done for exactly one cycle, then go to IDLE.
REQ-022 Latency: normal division SHALL assert done in the (N+2)th cycle after the start-sampling edge; dbz/ovf cases SHALL assert done in the next cycle.
REQ-023 start SHALL be ignored in RUN, FIX and DONE; no queuing.
REQ-024 quotient, remainder, dbz, ovf SHALL hold from the done cycle until the next accepted start loads new values.
REQ-025 Result SHALL satisfy dividend == quotient*divisor + remainder with remainder < divisor for every non-error case.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE and clear quotient, remainder, busy, done, dbz, ovf, count and internal R/Q to 0, overriding start.
REQ-027 rst asserted mid-RUN or mid-FIX SHALL abort the operation without producing done; the next start after reset release SHALL divide normally.

Verification
REQ-028 N=25: dividend=100, divisor=7, start one cycle -> done exactly 27 cycles later; quotient=14, remainder=2, dbz=0, ovf=0.
REQ-029 dividend=0x1FFFFFF*0x1FFFFFF, divisor=0x1FFFFFF -> quotient=0x1FFFFFF, remainder=0, flags 0.
REQ-030 divisor=0, dividend=123 -> done next cycle; dbz=1, quotient=0, remainder=0; busy never high.
REQ-031 dividend={25'd7,25'd0}, divisor=7 -> done next cycle; ovf=1, quotient=0x1FFFFFF, remainder=0.
REQ-032 start 100/7, rst pulsed at iteration 10 -> no done, outputs 0; then 50/5 -> quotient=10, remainder=0; start pulses while busy are ignored.
REQ-033 Randomised 10k pairs with dividend[49:25] < divisor != 0 -> REQ-025 identity holds; done width always 1 cycle.
